// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings and FSM states.
package alu_serial_seq_pkg;

    // op[2] = arit, op[1:0] = s
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result bundle between the control unit (master) and the serial ALU (slave).
// ALU_SERIAL_OVF_EN adds the registered signed-overflow flag ovf.
interface alu_serial_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, op, a, b,
        input  busy, done, y, cout, zero
`ifdef ALU_SERIAL_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y, cout, zero
`ifdef ALU_SERIAL_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/alu_serial_seq_cal.sv
// One-bit arithmetic/logic cell: full adder when arit=1, else AND/OR/XOR/NOT A by s.
module cal
    import alu_serial_seq_pkg::*;
(
    output logic       out,
    output logic       c_out,
    input  logic       a,
    input  logic       b,
    input  logic       arit,
    input  logic       c_in,
    input  logic [1:0] s
);
    // Combinational cell function; carry out is only meaningful for arithmetic.
    always_comb begin
        out   = 1'b0;
        c_out = 1'b0;
        if (arit) begin
            out   = a ^ b ^ c_in;
            c_out = (a & b) | (a & c_in) | (b & c_in);
        end else begin
            case ({1'b0, s})
                OP_AND:  out = a & b;
                OP_OR:   out = a | b;
                OP_XOR:  out = a ^ b;
                OP_NOTA: out = ~a;
                default: out = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds operands LSB-first through one cal cell, one bit
// per clock, and assembles result and flags. ALU_SERIAL_OVF_EN adds the ovf flag.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_serial_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-2:0]   r_sh_q, r_sh_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
`ifdef ALU_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               arit;
    logic               b_eff;
    logic               cell_out;
    logic               cell_cout;
    logic               last;

    assign arit  = op_q[2];
    assign b_eff = b_sh_q[0] ^ (arit & op_q[0]);
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

    cal u_cal (
        .out   (cell_out),
        .c_out (cell_cout),
        .a     (a_sh_q[0]),
        .b     (b_eff),
        .arit  (arit),
        .c_in  (carry_q),
        .s     (op_q[1:0])
    );

    // Next state and datapath updates for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    carry_d = bus.op[2] & bus.op[0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {cell_out, r_sh_q} >> 1;
                carry_d = arit & cell_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    // The result bits never sit in y while shifting, so y only
                    // moves on the edge into DONE.
                    y_d     = {cell_out, r_sh_q};
                    cout_d  = arit & cell_cout;
                    zero_d  = ({cell_out, r_sh_q} == '0);
`ifdef ALU_SERIAL_OVF_EN
                    ovf_d   = arit & (carry_q ^ cell_cout);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expected results are queued as each request
// is driven and popped when done pulses. ALU_SERIAL_OVF_EN also checks ovf.
module tb_alu_serial_seq;
    import alu_serial_seq_pkg::*;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             cout;
        logic             zero;
        logic             ovf;
        int unsigned      due;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned total;
    int unsigned bad;
    int unsigned busy_cnt;
    logic [WIDTH-1:0] y_hold;
    exp_t        sb[$];

    alu_serial_seq_if #(.WIDTH(WIDTH)) bus_if ();

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] sum;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        e.due  = 0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                e.y    = sum[WIDTH-1:0];
                e.cout = sum[WIDTH];
                e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + 1;
                e.y    = sum[WIDTH-1:0];
                e.cout = sum[WIDTH];
                e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  e.y = a & b;
            OP_OR:   e.y = a | b;
            OP_XOR:  e.y = a ^ b;
            OP_NOTA: e.y = ~a;
            default: e.y = '0;
        endcase
        e.zero = (e.y == '0);
        return e;
    endfunction

    // Issue one request in the coming IDLE cycle; push its expectation if it should complete.
    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        if (push) begin
            e     = model(op, a, b);
            e.due = cyc + 1 + WIDTH;
            sb.push_back(e);
        end
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            busy_cnt = 0;
            y_hold   = '0;
        end else begin
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("y",       32'(bus_if.y),    32'(e.y));
                    chk("cout",    32'(bus_if.cout), 32'(e.cout));
                    chk("zero",    32'(bus_if.zero), 32'(e.zero));
`ifdef ALU_SERIAL_OVF_EN
                    chk("ovf",     32'(bus_if.ovf),  32'(e.ovf));
`endif
                    chk("latency", cyc,              e.due);
                    chk("busy_cycles", busy_cnt,     WIDTH);
                    chk("busy_in_done", 32'(bus_if.busy), 32'd0);
                    y_hold = e.y;
                end
                busy_cnt = 0;
            end else begin
                chk("y_hold", 32'(bus_if.y), 32'(y_hold));
            end
        end
    end

    initial begin
        logic [2:0] ops [6];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOTA};
        total    = 0;
        bad      = 0;
        cyc      = 0;
        busy_cnt = 0;
        y_hold   = '0;
        reset    = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = '0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_y",    32'(bus_if.y),    32'd0);
        chk("rst_cout", 32'(bus_if.cout), 32'd0);
        chk("rst_zero", 32'(bus_if.zero), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
        chk("rst_ovf",  32'(bus_if.ovf),  32'd0);
`endif
        reset = 1'b0;

        // Arithmetic and logic directed cases
        drive(OP_ADD, 8'h3C, 8'h05, 1'b1); wait_done();
        drive(OP_SUB, 8'h05, 8'h06, 1'b1); wait_done();
        drive(OP_SUB, 8'h06, 8'h06, 1'b1); wait_done();
        drive(OP_AND,  8'hF0, 8'h3C, 1'b1); wait_done();
        drive(OP_OR,   8'hF0, 8'h3C, 1'b1); wait_done();
        drive(OP_XOR,  8'hF0, 8'h3C, 1'b1); wait_done();
        drive(OP_NOTA, 8'hF0, 8'h3C, 1'b1); wait_done();

        // start pulsed mid-SHIFT must be ignored
        drive(OP_ADD, 8'h10, 8'h01, 1'b1);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = 8'hFF;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done();
        chk("ignored_start_y", 32'(bus_if.y), 32'h11);

        // start raised during DONE is ignored; the IDLE cycle after accepts
        bus_if.start = 1'b1;
        bus_if.op    = OP_SUB;
        bus_if.a     = 8'hEE;
        bus_if.b     = 8'h01;
        drive(OP_ADD, 8'hAA, 8'h55, 1'b1); wait_done();

        // Reset three cycles into an operation aborts it with no done
        drive(OP_ADD, 8'hFF, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_done", 32'(bus_if.done), 32'd0);
        chk("abort_y",    32'(bus_if.y),    32'd0);
        chk("abort_cout", 32'(bus_if.cout), 32'd0);
        reset = 1'b0;
        drive(OP_ADD, 8'hFF, 8'h01, 1'b1); wait_done();

`ifdef ALU_SERIAL_OVF_EN
        drive(OP_ADD, 8'h7F, 8'h01, 1'b1); wait_done();
        drive(OP_SUB, 8'h80, 8'h01, 1'b1); wait_done();
        drive(OP_ADD, 8'h01, 8'h01, 1'b1); wait_done();
`endif

        // Random back-to-back operations
        for (int i = 0; i < 12; i++) begin
            drive(ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom), 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
Bit-serial ALU sequencer: the control/driving end of the one-bit arithmetic-logic cell. It accepts a WIDTH-bit operation on a start strobe and feeds operand bits LSB-first into a single one-bit cell, one bit per clock. It also drives the cell's arit/s/c_in inputs, registers the carry between bits, and assembles the result and flags. It sits between the control unit and the register file in the multicycle datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
op  input  3  op[2]=arit (1 arithmetic, 0 logic), op[1:0]=s
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result is valid
y  output  WIDTH  result; held stable from done until next accepted start
cout  output  1  final carry (arithmetic ops), else 0
zero  output  1  y == 0, valid with done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, y=0, cout=0, zero=0; counter and carry flop cleared. Reset mid-operation aborts immediately; no done is produced.
- States:
  - IDLE: start=1 latches a, b, op into shift registers; cnt=0; carry=(arit & s[0]); next SHIFT. start=0 stays in IDLE.
  - SHIFT: busy=1. Each cycle the cell computes bit cnt from a_sh[0] and b_eff. b_eff = b_sh[0] ^ (arit & s[0]).
    - Cell result is shifted into y from the MSB (right shift); a_sh and b_sh shift right.
    - If arit=1, carry <= cell c_out; otherwise carry holds 0.
    - cnt increments; at cnt==WIDTH-1, next state is DONE.
  - DONE: one cycle. done=1, busy=0, cout=carry, zero=(y==0). Next state is IDLE.
- Ops:
  - arit=1: s[0]=0 ADD (c_in0=0); s[0]=1 SUB, A+~B+1 (cout=1 means no borrow). s[1] is ignored.
  - arit=0: logic function of the cell selected by s: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- Latency: accepted start at edge N gives done high in cycle N+WIDTH+1. Back-to-back: start may be accepted in the IDLE cycle right after DONE.
- start while busy or in DONE is ignored; inputs are not re-captured.
- y, cout and zero change only in DONE or on reset.

Optional Feature:
ALU_SERIAL_OVF_EN
- Defined: adds output port ovf (1 bit). ovf = arit & (carry into MSB XOR carry out of MSB), captured on the final SHIFT cycle. It is registered and presented with done. Reset value 0; ovf is 0 for logic ops.
- Undefined: no ovf port and no extra flop.

Decomposition:
- Shared package/header: the op encoding constants (OP_ADD=3'b100, OP_SUB=3'b101, OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NOTA=3'b011) and the state encoding (IDLE, SHIFT, DONE).
- One sub-module is natural: the existing one-bit cell cal, instantiated once. Its ports: out, c_out, a, b, arit, c_in, s.
- The sequencer only drives it; it does not re-implement adder or logic functions.

Test Plan:
- ADD a=8'h3C, b=8'h05, start 1 cycle -> busy for 8 cycles, done in cycle 9 after start; y=8'h41, cout=0, zero=0.
- SUB a=8'h05, b=8'h06 -> y=8'hFF, cout=0 (borrow), zero=0. SUB a=8'h06, b=8'h06 -> y=8'h00, cout=1, zero=1.
- Logic ops with a=8'hF0, b=8'h3C:
  - AND -> y=8'h30; OR -> 8'hFC; XOR -> 8'hCC; NOT A -> 8'h0F.
  - cout=0 for all four.
- ADD a=8'h10, b=8'h01, then start pulsed with a=8'hFF mid-SHIFT -> ignored; y=8'h11. A second start in the IDLE cycle after done is accepted.
- reset asserted 3 cycles into ADD 8'hFF+8'h01 -> next cycle busy=0, y=0, cout=0; no done pulse. A following ADD 8'hFF+8'h01 gives y=8'h00, cout=1, zero=1.
- With ALU_SERIAL_OVF_EN: ADD 8'h7F+8'h01 -> y=8'h80, ovf=1. SUB 8'h80-8'h01 -> y=8'h7F, ovf=1. ADD 8'h01+8'h01 -> ovf=0.
